gate_bist_ctrl: RTL and testbench
=================================

// Module: gate_bist_ctrl
// PURPOSE
//   Synthesizable self-test controller for a 2-input combinational gate.
//   On start it walks the 4 input vectors {a,b} = 00,01,10,11 into the gate under test.
//   For each vector it waits a settle window, samples y and checks it against a truth table.
//   Results are reported as a per-vector failure bitmap plus pass/done flags.
//   It sits beside any 2-input gate instance and replaces a simulation-only stimulus bench with on-chip checking.
// PARAMETERS
//   TRUTH_TABLE    4'b1000  expected y per vector index {a,b}; bit[i] = y for idx i (1000 = AND, 1110 = OR)
//   SETTLE_CYCLES  2        cycles between driving a vector and sampling y; legal range 1..255
// PORTS
//   clk       in   1  single clock; all state updates on posedge
//   rst_n     in   1  asynchronous, active-low reset
//   start     in   1  request a test run; sampled in IDLE or DONE only
//   y         in   1  output of the gate under test
//   a         out  1  stimulus input a to the gate under test (registered)
//   b         out  1  stimulus input b to the gate under test (registered)
//   busy      out  1  high while a run is in progress
//   done      out  1  high (level) from run completion until the next accepted start
//   pass      out  1  done && (fail_vec == 0)
//   fail_vec  out  4  bit i set if y mismatched TRUTH_TABLE[i] for vector idx i
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, idx=0, cnt=0, a=0, b=0, busy=0, done=0, pass=0, fail_vec=0.
//   States:
//   - IDLE
//   - APPLY
//   - SETTLE
//   - SAMPLE
//   - DONE
//   Derived flags: busy = state in {APPLY,SETTLE,SAMPLE}; done = (state==DONE); pass = done & ~|fail_vec.
//   IDLE/DONE + start=1 at an edge:
//   - go to APPLY; idx<=0; fail_vec<=0.
//   - done/pass drop at the same edge.
//   APPLY: {a,b}<=idx; cnt<=SETTLE_CYCLES-1; next state SETTLE.
//   SETTLE: cnt decrements each cycle; when cnt==0, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
//   SAMPLE:
//   - if y != TRUTH_TABLE[idx], set fail_vec[idx] (bits are never cleared mid-run).
//   - if idx==3, go to DONE; else idx<=idx+1 and go to APPLY.
//   - idx is 2 bits and never wraps during a run.
//   Timing: each vector takes SETTLE_CYCLES+2 cycles. With start sampled at edge k, done rises after edge k+4*(SETTLE_CYCLES+2); default = k+16.
//   a and b hold the last applied vector (11) in DONE. They return to 00 only on reset or at the next APPLY.
//   start while busy: ignored; the run continues unaffected.
//   start held high in DONE: a new run begins immediately (back-to-back runs are allowed).
//   y is sampled only in SAMPLE; y glitches during SETTLE have no effect.
//   Reset mid-run: abort immediately to reset values; no partial result is retained.
//   cnt is 8 bits wide. SETTLE_CYCLES=0 is illegal; flag it with a simulation-time $error in an initial block.
// CONFIGURATION
//   GATE_BIST_FIRST_FAIL_EN defined:
//   - adds outputs first_fail_valid (1b) and first_fail_idx (2b), both reset to 0 and cleared on an accepted start.
//   - on the first mismatch of a run: first_fail_valid<=1 and first_fail_idx<=idx; both then hold until the next start.
//   GATE_BIST_FIRST_FAIL_EN undefined: these ports and their registers do not exist; all other behaviour is identical.
// TESTING
//   1. AND gate DUT, default params, start pulse at edge k -> busy high k+1..k+16; done=1, pass=1, fail_vec=4'b0000 after edge k+16.
//   2. OR gate DUT, TRUTH_TABLE=4'b1000 -> fail_vec=4'b0110, pass=0. With GATE_BIST_FIRST_FAIL_EN: first_fail_valid=1, first_fail_idx=2'b01.
//   3. y tied to 0 -> fail_vec=4'b1000, pass=0. Also check the a/b sequence is 00,01,10,11, with each vector held 4 cycles.
//   4. Pulse start again at edges k+3 and k+9 of a run -> no restart; done still rises after edge k+16 with the same results as scenario 1.
//   5. Assert rst_n=0 while idx=2 in SETTLE -> all outputs 0 at once. After release, start -> full correct run from vector 00.
//   6. SETTLE_CYCLES=5, AND DUT -> done after edge k+28, pass=1. Then hold start high in DONE -> done drops and a second run passes.

Source files
------------

// File: rtl/gate_bist_if.sv
// Bus between a BIST host and the gate_bist_ctrl self-test controller.
// Carries the run request, the gate-under-test stimulus/response pair and
// the result flags. With GATE_BIST_FIRST_FAIL_EN defined, the first-failure
// report (first_fail_valid / first_fail_idx) is added to the bus.
interface gate_bist_if;
   logic       start;
   logic       y;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_vec;
`ifdef GATE_BIST_FIRST_FAIL_EN
   logic       first_fail_valid;
   logic [1:0] first_fail_idx;

   // Host side: requests runs and returns the gate response.
   modport master (
      output start, y,
      input  a, b, busy, done, pass, fail_vec, first_fail_valid, first_fail_idx
   );

   // Controller side: drives stimulus and reports results.
   modport slave (
      input  start, y,
      output a, b, busy, done, pass, fail_vec, first_fail_valid, first_fail_idx
   );
`else
   // Host side: requests runs and returns the gate response.
   modport master (
      output start, y,
      input  a, b, busy, done, pass, fail_vec
   );

   // Controller side: drives stimulus and reports results.
   modport slave (
      input  start, y,
      output a, b, busy, done, pass, fail_vec
   );
`endif
endinterface

// File: rtl/gate_bist_ctrl.sv
// Self-test controller for a 2-input combinational gate.
// Walks {a,b} = 00,01,10,11 into the gate, waits SETTLE_CYCLES per vector,
// samples y and records mismatches against TRUTH_TABLE in fail_vec.
// Optional feature macro: GATE_BIST_FIRST_FAIL_EN adds a first-failure
// report (valid flag plus vector index) that holds until the next start.
module gate_bist_ctrl #(
   parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic        clk,
   input logic        rst_n,
   gate_bist_if.slave bist_if
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   // Settle counter load value; SETTLE counts this down to zero.
   localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

`ifndef SYNTHESIS
   // A zero settle window cannot be represented by the counter.
   initial begin
      if (SETTLE_CYCLES == 0)
         $error("gate_bist_ctrl: SETTLE_CYCLES must be in 1..255");
   end
`endif

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic       a_q, a_d;
   logic       b_q, b_d;
   logic [3:0] fail_vec_q, fail_vec_d;
`ifdef GATE_BIST_FIRST_FAIL_EN
   logic       ff_valid_q, ff_valid_d;
   logic [1:0] ff_idx_q, ff_idx_d;
`endif

   // State register: any reset aborts the run and discards partial results.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         fail_vec_q <= '0;
`ifdef GATE_BIST_FIRST_FAIL_EN
         ff_valid_q <= 1'b0;
         ff_idx_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         fail_vec_q <= fail_vec_d;
`ifdef GATE_BIST_FIRST_FAIL_EN
         ff_valid_q <= ff_valid_d;
         ff_idx_q   <= ff_idx_d;
`endif
      end
   end

   // Next-state logic: sequences apply / settle / sample for each vector.
   always_comb begin
      // NOTE: every signal gets a hold-value default before the case, so no
      // path leaves a variable unassigned and no latch is inferred.
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      fail_vec_d = fail_vec_q;
`ifdef GATE_BIST_FIRST_FAIL_EN
      ff_valid_d = ff_valid_q;
      ff_idx_d   = ff_idx_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            // a/b keep the last vector until the next APPLY.
            if (bist_if.start) begin
               state_d    = S_APPLY;
               idx_d      = '0;
               fail_vec_d = '0;
`ifdef GATE_BIST_FIRST_FAIL_EN
               ff_valid_d = 1'b0;
               ff_idx_d   = '0;
`endif
            end
         end
         S_APPLY: begin
            {a_d, b_d} = idx_q;
            cnt_d      = SETTLE_INIT;
            state_d    = S_SETTLE;
         end
         S_SETTLE: begin
            // y is ignored here, so glitches while settling are harmless.
            if (cnt_q == '0) state_d = S_SAMPLE;
            else             cnt_d   = cnt_q - 8'd1;
         end
         S_SAMPLE: begin
            if (bist_if.y != TRUTH_TABLE[idx_q]) begin
               fail_vec_d[idx_q] = 1'b1;
`ifdef GATE_BIST_FIRST_FAIL_EN
               if (!ff_valid_q) begin
                  ff_valid_d = 1'b1;
                  ff_idx_d   = idx_q;
               end
`endif
            end
            if (idx_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = S_APPLY;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bist_if.a        = a_q;
   assign bist_if.b        = b_q;
   assign bist_if.busy     = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                             (state_q == S_SAMPLE);
   assign bist_if.done     = (state_q == S_DONE);
   assign bist_if.pass     = (state_q == S_DONE) && (fail_vec_q == '0);
   assign bist_if.fail_vec = fail_vec_q;
`ifdef GATE_BIST_FIRST_FAIL_EN
   assign bist_if.first_fail_valid = ff_valid_q;
   assign bist_if.first_fail_idx   = ff_idx_q;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: two controllers (settle windows 2 and 5) check a
// behavioural gate whose function the bench changes per scenario. A timeline
// model (cycles since start) predicts every output; directed scenarios pin
// the model with hand-computed values, then a randomized phase follows.
module tb_gate_bist_ctrl;

   localparam logic [3:0] TT = 4'b1000;

   typedef struct packed {
      logic       active;
      logic       done;
      logic [7:0] t;
      logic [3:0] fail;
      logic [1:0] ab;
      logic       ffv;
      logic [1:0] ffi;
   } model_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] gate_tt;
   logic       glitch2, glitch5;
   int         n_cmp, n_err;
   model_t     m2, m5;

   gate_bist_if if_s2();
   gate_bist_if if_s5();

   assign if_s2.start = start;
   assign if_s5.start = start;
   assign if_s2.y     = gate_tt[{if_s2.a, if_s2.b}] ^ glitch2;
   assign if_s5.y     = gate_tt[{if_s5.a, if_s5.b}] ^ glitch5;

   gate_bist_ctrl #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(2)) dut_s2 (
      .clk(clk), .rst_n(rst_n), .bist_if(if_s2)
   );
   gate_bist_ctrl #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(5)) dut_s5 (
      .clk(clk), .rst_n(rst_n), .bist_if(if_s5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Run timeline: after acceptance, vector v occupies t = v*(s+2) .. v*(s+2)+s+1;
   // the vector is applied at the first of those cycles and y judged at the last.
   function automatic model_t model_step(input model_t m, input int s, input logic st, input logic y);
      model_t n;
      int per, v;
      n   = m;
      per = s + 2;
      v   = int'(m.t) / per;
      if (!m.active) begin
         if (st) begin
            n.active = 1'b1;
            n.done   = 1'b0;
            n.t      = '0;
            n.fail   = '0;
            n.ffv    = 1'b0;
            n.ffi    = '0;
         end
      end else begin
         if (int'(m.t) % per == 0) n.ab = 2'(v);
         if (int'(m.t) % per == per - 1) begin
            if (y !== TT[v]) begin
               n.fail[v] = 1'b1;
               if (!m.ffv) begin
                  n.ffv = 1'b1;
                  n.ffi = 2'(v);
               end
            end
            if (v == 3) begin
               n.active = 1'b0;
               n.done   = 1'b1;
            end
         end
         n.t = m.t + 8'd1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2 <= '0;
         m5 <= '0;
      end else begin
         m2 <= model_step(m2, 2, start, if_s2.y);
         m5 <= model_step(m5, 5, start, if_s5.y);
      end
   end

   task automatic cmp_dut(input string tag, input model_t m, input logic busy, input logic done,
                          input logic pass, input logic a, input logic b, input logic [3:0] fv,
                          input logic ffv, input logic [1:0] ffi);
      check({tag, ".busy"}, 32'(busy), 32'(m.active));
      check({tag, ".done"}, 32'(done), 32'(m.done));
      check({tag, ".pass"}, 32'(pass), 32'(m.done && (m.fail == 4'b0000)));
      check({tag, ".fail_vec"}, 32'(fv), 32'(m.fail));
      check({tag, ".ab"}, 32'({a, b}), 32'(m.ab));
`ifdef GATE_BIST_FIRST_FAIL_EN
      check({tag, ".ff_valid"}, 32'(ffv), 32'(m.ffv));
      check({tag, ".ff_idx"}, 32'(ffi), 32'(m.ffi));
`else
      if (ffv || (ffi != 2'b00)) check({tag, ".ff_tieoff"}, 32'({ffv, ffi}), 32'd0);
`endif
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
`ifdef GATE_BIST_FIRST_FAIL_EN
      cmp_dut("s2", m2, if_s2.busy, if_s2.done, if_s2.pass, if_s2.a, if_s2.b, if_s2.fail_vec,
              if_s2.first_fail_valid, if_s2.first_fail_idx);
      cmp_dut("s5", m5, if_s5.busy, if_s5.done, if_s5.pass, if_s5.a, if_s5.b, if_s5.fail_vec,
              if_s5.first_fail_valid, if_s5.first_fail_idx);
`else
      cmp_dut("s2", m2, if_s2.busy, if_s2.done, if_s2.pass, if_s2.a, if_s2.b, if_s2.fail_vec,
              1'b0, 2'b00);
      cmp_dut("s5", m5, if_s5.busy, if_s5.done, if_s5.pass, if_s5.a, if_s5.b, if_s5.fail_vec,
              1'b0, 2'b00);
`endif
   end

   // One-cycle start pulse; returns at the falling edge after the accepting edge k.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [8:0] outs2();
      return {if_s2.busy, if_s2.done, if_s2.pass, if_s2.fail_vec, if_s2.a, if_s2.b};
   endfunction

   function automatic logic [8:0] outs5();
      return {if_s5.busy, if_s5.done, if_s5.pass, if_s5.fail_vec, if_s5.a, if_s5.b};
   endfunction

   logic [31:0] ab_seq;

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      gate_tt = 4'b1000;
      glitch2 = 1'b0;
      glitch5 = 1'b0;

      // Reset state.
      #3;
      check("reset.s2_outputs", 32'(outs2()), 32'd0);
      check("reset.s5_outputs", 32'(outs5()), 32'd0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // 1: AND gate, default timing.
      pulse_start();
      check("s1.busy_k1", 32'(if_s2.busy), 32'd1);
      repeat (15) @(negedge clk);
      check("s1.done_k15", 32'(if_s2.done), 32'd0);
      check("s1.busy_k15", 32'(if_s2.busy), 32'd1);
      @(negedge clk);
      check("s1.done_k16", 32'(if_s2.done), 32'd1);
      check("s1.pass_k16", 32'(if_s2.pass), 32'd1);
      check("s1.fail_vec", 32'(if_s2.fail_vec), 32'h0);
      check("s1.busy_k16", 32'(if_s2.busy), 32'd0);
      check("s1.ab_held", 32'({if_s2.a, if_s2.b}), 32'h3);
      repeat (30) @(negedge clk);

      // 2: OR gate against the AND table.
      gate_tt = 4'b1110;
      pulse_start();
      repeat (16) @(negedge clk);
      check("s2.done", 32'(if_s2.done), 32'd1);
      check("s2.pass", 32'(if_s2.pass), 32'd0);
      check("s2.fail_vec", 32'(if_s2.fail_vec), 32'h6);
`ifdef GATE_BIST_FIRST_FAIL_EN
      check("s2.ff_valid", 32'(if_s2.first_fail_valid), 32'd1);
      check("s2.ff_idx", 32'(if_s2.first_fail_idx), 32'd1);
`endif
      repeat (30) @(negedge clk);

      // 3: y stuck at 0; record the stimulus sequence cycle by cycle.
      gate_tt = 4'b0000;
      pulse_start();
      ab_seq = '0;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         ab_seq = {ab_seq[29:0], if_s2.a, if_s2.b};
      end
      check("s3.ab_sequence", ab_seq, 32'h0055AAFF);
      check("s3.fail_vec", 32'(if_s2.fail_vec), 32'h8);
      check("s3.pass", 32'(if_s2.pass), 32'd0);
      repeat (30) @(negedge clk);

      // 4: start pulses mid-run are ignored.
      gate_tt = 4'b1000;
      pulse_start();
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("s4.done_k15", 32'(if_s2.done), 32'd0);
      @(negedge clk);
      check("s4.done_k16", 32'(if_s2.done), 32'd1);
      check("s4.pass", 32'(if_s2.pass), 32'd1);
      check("s4.fail_vec", 32'(if_s2.fail_vec), 32'h0);
      repeat (30) @(negedge clk);

      // 5: reset while vector 10 is settling.
      pulse_start();
      repeat (9) @(negedge clk);
      check("s5.ab_before_rst", 32'({if_s2.a, if_s2.b}), 32'h2);
      check("s5.busy_before_rst", 32'(if_s2.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("s5.s2_outputs_rst", 32'(outs2()), 32'd0);
      check("s5.s5_outputs_rst", 32'(outs5()), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      pulse_start();
      repeat (16) @(negedge clk);
      check("s5.rerun_done", 32'(if_s2.done), 32'd1);
      check("s5.rerun_pass", 32'(if_s2.pass), 32'd1);
      repeat (30) @(negedge clk);

      // 6: five-cycle settle window, then back-to-back run with start held.
      pulse_start();
      repeat (27) @(negedge clk);
      check("s6.done_k27", 32'(if_s5.done), 32'd0);
      @(negedge clk);
      check("s6.done_k28", 32'(if_s5.done), 32'd1);
      check("s6.pass_k28", 32'(if_s5.pass), 32'd1);
      start = 1'b1;
      @(negedge clk);
      check("s6.done_drops", 32'(if_s5.done), 32'd0);
      check("s6.busy_again", 32'(if_s5.busy), 32'd1);
      start = 1'b0;
      repeat (28) @(negedge clk);
      check("s6.second_done", 32'(if_s5.done), 32'd1);
      check("s6.second_pass", 32'(if_s5.pass), 32'd1);

      // Randomized phase: random gate functions, start traffic, y glitches, resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start   = ($urandom_range(0, 5) == 0);
         glitch2 = ($urandom_range(0, 7) == 0);
         glitch5 = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 39) == 0) gate_tt = 4'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            #1 rst_n = 1'b0;
            @(negedge clk);
            #1 rst_n = 1'b1;
         end
      end
      start   = 1'b0;
      glitch2 = 1'b0;
      glitch5 = 1'b0;
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
